// File: rtl/fib_pkg.sv
// Shared types and default widths for the Fibonacci request scheduler.
package fib_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned N_W_DEF     = 8;
    localparam int unsigned RES_W_DEF   = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_engine.sv
// Iterative Fibonacci datapath: after start, each step advances (a,b) by one term
// until cnt reaches zero, at which point a holds F(n) mod 2^RES_W.
// Ports:
//   clock, reset_n  clock / async active-low reset
//   start           load a=0, b=1, cnt=n_in, clear overflow flags
//   n_in            requested index
//   step            advance one iteration (ignored once cnt==0)
//   done_c          cnt==0 (combinational)
//   value           current a
//   overflow        true value of a is >= 2^RES_W
module fib_engine
    import fib_pkg::*;
#(
    parameter int unsigned N_W   = N_W_DEF,
    parameter int unsigned RES_W = RES_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N_W-1:0]   n_in,
    input  logic             step,
    output logic             done_c,
    output logic [RES_W-1:0] value,
    output logic             overflow
);

    logic [RES_W-1:0] a;
    logic [RES_W-1:0] b;
    logic [N_W-1:0]   cnt;
    logic             a_ovf;
    logic             b_ovf;
    logic [RES_W:0]   sum_c;

    // Extra bit captures the carry out of the wrapped addition.
    assign sum_c = {1'b0, a} + {1'b0, b};

    // a_ovf/b_ovf track whether the true a/b exceed RES_W bits; once set they
    // propagate forward, so the flag stays correct for arbitrarily large n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (start) begin
            a     <= '0;
            b     <= RES_W'(1);
            cnt   <= n_in;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (step && (cnt != '0)) begin
            a     <= b;
            b     <= sum_c[RES_W-1:0];
            b_ovf <= b_ovf | a_ovf | sum_c[RES_W];
            a_ovf <= b_ovf;
            cnt   <= cnt - N_W'(1);
        end
    end

    assign done_c   = (cnt == '0);
    assign value    = a;
    assign overflow = a_ovf;

endmodule

// File: rtl/fib_request_scheduler.sv
// Shares one fib_engine among NUM_REQ requesters: round-robin arbitration in IDLE,
// engine sequencing in RUN, and a held valid/ready response in RESP.
// Ports:
//   clock, reset_n   clock / async active-low reset
//   req_valid        per-requester request valid
//   req_n            per-requester index n, slice i = [i*N_W +: N_W]
//   req_ready        one-hot grant, combinational, only in IDLE
//   rsp_valid        result valid
//   rsp_ready        result consumer ready
//   rsp_id           requester that issued the job
//   rsp_value        F(n) mod 2^RES_W
//   rsp_overflow     true F(n) >= 2^RES_W
//   busy             state != IDLE
module fib_request_scheduler
    import fib_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned N_W     = N_W_DEF,
    parameter int unsigned RES_W   = RES_W_DEF,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*N_W-1:0] req_n,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [RES_W-1:0]       rsp_value,
    output logic                   rsp_overflow,
    output logic                   busy
);

    fib_state_e       state;
    fib_state_e       state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic             found;
    int unsigned      arb_idx;
    logic [N_W-1:0]   win_n;
    logic             accept;
    logic             eng_start;
    logic             eng_step;
    logic             rsp_load;
    logic             rsp_done;
    logic             eng_done_c;
    logic [RES_W-1:0] eng_value;
    logic             eng_overflow;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        arb_idx = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = 32'(rr_ptr) + k;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            if (!found && req_valid[ID_W'(arb_idx)]) begin
                found  = 1'b1;
                winner = ID_W'(arb_idx);
            end
        end
    end

    // Index requested by the winner.
    always_comb begin
        win_n = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_n = req_n[i*N_W +: N_W];
            end
        end
    end

    // Next-state and control decode. req_ready is gated by reset_n so the grant
    // reads zero while reset is held, even if requests are pending.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        eng_start = 1'b0;
        eng_step  = 1'b0;
        rsp_load  = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = reset_n;
                    accept            = 1'b1;
                    eng_start         = 1'b1;
                    state_nxt         = RUN;
                end
            end
            RUN: begin
                if (eng_done_c) begin
                    rsp_load  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    eng_step = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbiter pointer, job id and response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_value    <= '0;
            rsp_overflow <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                rsp_id <= winner;
                busy   <= 1'b1;
            end
            if (rsp_load) begin
                rsp_valid    <= 1'b1;
                rsp_value    <= eng_value;
                rsp_overflow <= eng_overflow;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

    fib_engine #(
        .N_W   (N_W),
        .RES_W (RES_W)
    ) u_engine (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (eng_start),
        .n_in     (win_n),
        .step     (eng_step),
        .done_c   (eng_done_c),
        .value    (eng_value),
        .overflow (eng_overflow)
    );

endmodule

// File: tb/tb_fib_request_scheduler.sv
// Directed scoreboard bench for fib_request_scheduler (NUM_REQ=4, N_W=8, RES_W=20).
module tb_fib_request_scheduler;

    localparam int NUM_REQ = 4;
    localparam int N_W     = 8;
    localparam int RES_W   = 20;
    localparam int ID_W    = 2;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*N_W-1:0] req_n;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [RES_W-1:0]       rsp_value;
    logic                   rsp_overflow;
    logic                   busy;

    typedef struct {
        int               id;
        logic [RES_W-1:0] value;
        bit               ovf;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    fib_request_scheduler #(
        .NUM_REQ (NUM_REQ),
        .N_W     (N_W),
        .RES_W   (RES_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_n        (req_n),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_value    (rsp_value),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: value mod 2^RES_W plus a saturated true value for the overflow flag.
    function automatic void fib_model(input int n, output logic [RES_W-1:0] v, output bit o);
        longint unsigned ra = 0, rb = 1, rt;
        longint unsigned cap = 64'd1 << 40;
        logic [RES_W-1:0] va = '0, vb = RES_W'(1), vt;
        for (int k = 0; k < n; k++) begin
            rt = ra + rb;
            ra = rb;
            rb = (rt > cap) ? cap : rt;
            vt = va + vb;
            va = vb;
            vb = vt;
        end
        v = va;
        o = (ra >= (64'd1 << RES_W));
    endfunction

    task automatic wait_grant(output logic [NUM_REQ-1:0] g);
        int cyc = 0;
        while (req_ready == '0 && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("grant_seen", 64'(req_ready != '0), 1);
        g = req_ready;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!rsp_valid && lat < 600);
        chk("rsp_seen", 64'(rsp_valid), 1);
    endtask

    task automatic pop_compare();
        exp_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_value", 64'(rsp_value), 64'(e.value));
            chk("rsp_overflow", 64'(rsp_overflow), 64'(e.ovf));
        end
    endtask

    task automatic push_exp(input int id, input int n);
        exp_t e;
        e.id = id;
        fib_model(n, e.value, e.ovf);
        sb.push_back(e);
    endtask

    // Requests already driven; expects requester id to win, runs job to handshake.
    task automatic serve(input int id, input int n, input bit drop, output int lat);
        logic [NUM_REQ-1:0] g;
        wait_grant(g);
        chk("grant", 64'(g), 64'(1) << id);
        push_exp(id, n);
        @(posedge clock); #1;
        if (drop) req_valid[id] = 1'b0;
        chk("busy_run", 64'(busy), 1);
        wait_rsp(lat);
        pop_compare();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_clear", 64'(rsp_valid), 0);
    endtask

    task automatic do_job(input int id, input int n, output int lat);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_n[id*N_W +: N_W] = N_W'(n);
        #1;
        serve(id, n, 1'b1, lat);
    endtask

    initial begin
        int lat;
        int bad;
        logic [NUM_REQ-1:0] g;

        reset_n   = 1'b0;
        req_valid = '0;
        req_n     = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_id", 64'(rsp_id), 0);
        chk("rst_rsp_value", 64'(rsp_value), 0);
        chk("rst_rsp_overflow", 64'(rsp_overflow), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;

        // All four requesting continuously with n=5: grant order 0,1,2,3,0.
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_n[i*N_W +: N_W] = N_W'(5);
        #1;
        for (int j = 0; j < 5; j++) begin
            serve(j % NUM_REQ, 5, 1'b0, lat);
            chk("rr_latency", 64'(lat), 6);
        end
        req_valid = '0;
        @(posedge clock); #1;

        do_job(0, 10, lat);  chk("lat_n10", 64'(lat), 11);
        do_job(1, 0, lat);   chk("lat_n0", 64'(lat), 1);
        do_job(2, 1, lat);   chk("lat_n1", 64'(lat), 2);
        do_job(3, 30, lat);  chk("lat_n30", 64'(lat), 31);
        do_job(0, 31, lat);
        do_job(1, 255, lat); chk("lat_n255", 64'(lat), 256);

        // Response held with rsp_ready low while another requester is waiting.
        req_valid = 4'b0010;
        req_n[1*N_W +: N_W] = N_W'(9);
        #1;
        wait_grant(g);
        chk("hold_grant", 64'(g), 64'b0010);
        push_exp(1, 9);
        @(posedge clock); #1;
        req_valid = 4'b1000;
        req_n[3*N_W +: N_W] = N_W'(6);
        wait_rsp(lat);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(1) || rsp_value !== sb[0].value ||
                req_ready !== '0 || busy !== 1'b1) bad++;
            @(posedge clock); #1;
        end
        chk("hold_stable_cycles_bad", 64'(bad), 0);
        pop_compare();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("hold_released", 64'(rsp_valid), 0);
        serve(3, 6, 1'b1, lat);

        // Reset in the middle of a long job; pointer must return to requester 0.
        req_valid = 4'b0100;
        req_n[2*N_W +: N_W] = N_W'(40);
        #1;
        wait_grant(g);
        chk("abort_grant", 64'(g), 64'b0100);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (7) @(posedge clock);
        #1;
        chk("abort_busy", 64'(busy), 1);
        req_valid = 4'b1100;
        req_n[2*N_W +: N_W] = N_W'(3);
        req_n[3*N_W +: N_W] = N_W'(7);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_rsp_id", 64'(rsp_id), 0);
        chk("mid_rst_rsp_value", 64'(rsp_value), 0);
        chk("mid_rst_rsp_overflow", 64'(rsp_overflow), 0);
        chk("mid_rst_req_ready", 64'(req_ready), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        serve(2, 3, 1'b1, lat);
        chk("post_rst_lat", 64'(lat), 4);
        serve(3, 7, 1'b1, lat);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
